// File: rtl/add2_acc_pkg.sv
// Shared types, constants and elaboration helpers for the 2-bit-adder sum accumulator.
package add2_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  localparam int SUM_W      = 3;
  localparam int MAX_SAMPLE = 6;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // The accumulator must at least hold one full-scale sample.
  function automatic bit acc_w_ok(input int acc_w);
    return (acc_w >= SUM_W) && (((1 << acc_w) - 1) >= MAX_SAMPLE);
  endfunction

endpackage

// File: rtl/add2_sat_add.sv
// Combinational ACC_W-bit saturating add of a zero-extended 3-bit adder sum.
module add2_sat_add
  import add2_acc_pkg::*;
#(
  parameter int ACC_W = 5
) (
  input  logic [ACC_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, a} + (ACC_W+1)'(b);
    sat  = wide[ACC_W];
    sum  = sat ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/add2_sum_accumulator.sv
// Frames FRAME_LEN adder sums into a saturating total and hands it out on a
// valid/ready port, overlapping the next frame with an unclaimed result.
module add2_sum_accumulator
  import add2_acc_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int CNT_W = clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  if (!acc_w_ok(ACC_W)) begin : g_bad_acc_w
    $error("add2_sum_accumulator: ACC_W too small for a 3-bit sample");
  end
  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("add2_sum_accumulator: FRAME_LEN must be at least 2");
  end

  acc_state_t       state, next_state;
  logic [ACC_W-1:0] acc;
  logic             sat_acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] nsum;
  logic             nsat;
  logic             accept, take, complete;

  add2_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   ({s2, s1, s0}),
    .sum (nsum),
    .sat (nsat)
  );

  // A second frame may not finish while the previous result is still unclaimed.
  always_comb begin
    in_ready   = (state == ACCUM) || !((cnt == LAST) && !out_ready);
    accept     = in_valid && in_ready;
    take       = out_valid && out_ready;
    complete   = accept && (cnt == LAST);
    next_state = state;
    case (state)
      ACCUM: if (complete) next_state = HOLD;
      HOLD:  if (!complete && take) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ACCUM;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      sat_acc   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (accept) begin
        if (complete) begin
          acc     <= '0;
          sat_acc <= 1'b0;
          cnt     <= '0;
        end else begin
          acc     <= nsum;
          sat_acc <= sat_acc | nsat;
          cnt     <= cnt + 1'b1;
        end
      end
      // A completion on the same cycle as a take reloads without a bubble.
      if (complete) begin
        out_sum   <= nsum;
        out_sat   <= sat_acc | nsat;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add2_sum_accumulator.sv
// Scoreboard bench for add2_sum_accumulator: a 5-bit and a 3-bit instance share stimulus.
module tb_add2_sum_accumulator;

  localparam int FL = 4;

  typedef struct {
    int sum;
    bit sat;
  } res_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_sat;
  logic [4:0] out_sum;
  logic       in_ready_s, out_valid_s, out_sat_s;
  logic [2:0] out_sum_s;

  res_t q5[$];
  res_t q3[$];
  int   m_cnt, m_acc5, m_acc3;
  bit   m_sat5, m_sat3;
  bit   exp_ir, obs_ir;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  add2_sum_accumulator #(.FRAME_LEN(FL), .ACC_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .s0(s0), .s1(s1), .s2(s2), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat)
  );

  add2_sum_accumulator #(.FRAME_LEN(FL), .ACC_W(3)) dut_small (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .s0(s0), .s1(s1), .s2(s2), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_sat(out_sat_s)
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    {s2, s1, s0} = 3'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    q5.delete(); q3.delete();
    m_cnt = 0; m_acc5 = 0; m_acc3 = 0; m_sat5 = 0; m_sat3 = 0;
  endtask

  // Drives one cycle and advances the reference model; returns at posedge+1.
  task automatic drive(input bit valid, input int v, input bit ready);
    int  n5, n3;
    bit  st5, st3, acc;
    @(negedge clock);
    in_valid = valid; {s2, s1, s0} = 3'(v); out_ready = ready;
    exp_ir = (q5.size() == 0) || !((m_cnt == FL - 1) && !ready);
    acc    = valid && exp_ir;
    #1 obs_ir = in_ready;
    @(posedge clock);
    if (q5.size() != 0 && ready) begin
      void'(q5.pop_front());
      void'(q3.pop_front());
    end
    if (acc) begin
      n5 = m_acc5 + v; st5 = 0; if (n5 > 31) begin n5 = 31; st5 = 1; end
      n3 = m_acc3 + v; st3 = 0; if (n3 > 7)  begin n3 = 7;  st3 = 1; end
      if (m_cnt == FL - 1) begin
        q5.push_back('{n5, m_sat5 | st5});
        q3.push_back('{n3, m_sat3 | st3});
        m_cnt = 0; m_acc5 = 0; m_acc3 = 0; m_sat5 = 0; m_sat3 = 0;
      end else begin
        m_cnt++; m_acc5 = n5; m_acc3 = n3;
        m_sat5 = m_sat5 | st5; m_sat3 = m_sat3 | st3;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_sum !== 5'd0) begin fails++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum); end
    tests++; if (out_sat !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_sat: got %b expected 0", out_sat); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    int vals[4] = '{3, 6, 1, 2};
    for (int i = 0; i < 3; i++) drive(1, vals[i], 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid); end
    drive(1, vals[3], 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
    tests++; if (out_sum !== 5'(q5[0].sum)) begin fails++; $display("[TB] FAIL basic_sum: got %0d expected %0d", out_sum, q5[0].sum); end
    tests++; if (out_sat !== q5[0].sat) begin fails++; $display("[TB] FAIL basic_sat: got %b expected %b", out_sat, q5[0].sat); end
    drive(0, 0, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) drive(1, 1, 0);
    tests++; if (out_sum !== 5'(q5[0].sum) || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_first: got %0d/%b expected %0d/1", out_sum, out_valid, q5[0].sum); end
    for (int i = 0; i < 3; i++) drive(1, 2, 0);
    drive(1, 2, 0);
    tests++; if (obs_ir !== exp_ir) begin fails++; $display("[TB] FAIL bp_in_ready_block: got %b expected %b", obs_ir, exp_ir); end
    tests++; if (out_sum !== 5'(q5[0].sum)) begin fails++; $display("[TB] FAIL bp_hold_sum: got %0d expected %0d", out_sum, q5[0].sum); end
    drive(1, 2, 1);
    tests++; if (obs_ir !== exp_ir) begin fails++; $display("[TB] FAIL bp_in_ready_release: got %b expected %b", obs_ir, exp_ir); end
    tests++; if (out_valid !== 1'b1 || out_sum !== 5'(q5[0].sum)) begin fails++; $display("[TB] FAIL bp_reload: got %0d/%b expected %0d/1", out_sum, out_valid, q5[0].sum); end
    drive(0, 0, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    int vals[8] = '{6, 6, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 4; i++) drive(1, vals[i], 1);
    tests++; if (out_sum_s !== 3'(q3[0].sum)) begin fails++; $display("[TB] FAIL sat_sum: got %0d expected %0d", out_sum_s, q3[0].sum); end
    tests++; if (out_sat_s !== q3[0].sat) begin fails++; $display("[TB] FAIL sat_flag: got %b expected %b", out_sat_s, q3[0].sat); end
    tests++; if (out_sum !== 5'(q5[0].sum) || out_sat !== q5[0].sat) begin fails++; $display("[TB] FAIL sat_wide: got %0d/%b expected %0d/%b", out_sum, out_sat, q5[0].sum, q5[0].sat); end
    for (int i = 4; i < 8; i++) drive(1, vals[i], 1);
    tests++; if (out_sum_s !== 3'(q3[0].sum) || out_valid_s !== 1'b1) begin fails++; $display("[TB] FAIL sat_next_sum: got %0d/%b expected %0d/1", out_sum_s, out_valid_s, q3[0].sum); end
    tests++; if (out_sat_s !== q3[0].sat) begin fails++; $display("[TB] FAIL sat_flag_cleared: got %b expected %b", out_sat_s, q3[0].sat); end
    drive(0, 0, 1);
  endtask

  task automatic test_mid_reset();
    drive(1, 5, 1);
    drive(1, 5, 1);
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 3; i++) drive(1, 1, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_early_valid: got %b expected 0", out_valid); end
    drive(1, 1, 1);
    tests++; if (out_sum !== 5'(q5[0].sum) || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL midrst_sum: got %0d/%b expected %0d/1", out_sum, out_valid, q5[0].sum); end
    drive(0, 0, 1);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 6; i++) drive((i % 2) == 0, 6, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL gaps_early_valid: got %b expected 0", out_valid); end
    drive(1, 6, 1);
    tests++; if (out_valid !== 1'b1 || out_sum !== 5'(q5[0].sum)) begin fails++; $display("[TB] FAIL gaps_sum: got %0d/%b expected %0d/1", out_sum, out_valid, q5[0].sum); end
    tests++; if (out_sum_s !== 3'(q3[0].sum) || out_sat_s !== q3[0].sat) begin fails++; $display("[TB] FAIL gaps_small: got %0d/%b expected %0d/%b", out_sum_s, out_sat_s, q3[0].sum, q3[0].sat); end
  endtask

  task automatic test_reset_while_holding();
    for (int i = 0; i < 4; i++) drive(1, 3, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL hold_before_reset: got %b expected 1", out_valid); end
    do_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL hold_reset_valid: got %b expected 0", out_valid); end
    tests++; if (out_sum !== 5'd0) begin fails++; $display("[TB] FAIL hold_reset_sum: got %0d expected 0", out_sum); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL hold_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_gaps();
    test_reset_while_holding();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
